dbuf_write_sched: RTL and testbench
===================================

Name: dbuf_write_sched

Overview:
- Ping-pong write scheduler for the two blocking buffers that feed the systolic array.
- Accepts AXI4 write-address bursts from the DMA and grants the target buffer. It steers W-channel beats to that buffer, checks burst legality, and generates the B response.
- Alternates buffers so one loads while the other pushes rows into the array.
- Sits between the DMA AXI slave port and two blocking buffer slaves.

Parameters:
- AXI_DW_g, 64, write data width (informational; beats are counted, not data).
- AXI_AW_g, 32, address width of s_axi_awaddr_i.
- BEATS_g, 16, beats per legal burst; equals buffer depth; legal awlen = BEATS_g-1.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- s_axi_awvalid_i  in  1  AW valid
- s_axi_awready_o  out  1  AW ready
- s_axi_awaddr_i  in  AXI_AW_g  burst address; ignored except low 3 bits, which must be 0
- s_axi_awlen_i  in  8  burst length-1
- s_axi_awsize_i  in  3  beat size; legal value 3'd3
- s_axi_awburst_i  in  2  burst type; legal value 2'b01 (INCR)
- s_axi_wvalid_i  in  1  W valid (observed)
- s_axi_wready_i  in  1  W ready from selected buffer, muxed externally by wsel_o
- s_axi_wlast_i  in  1  W last
- s_axi_bvalid_o  out  1  B valid
- s_axi_bready_i  in  1  B ready
- s_axi_bresp_o  out  2  2'b00 OKAY, 2'b10 SLVERR
- buf_available_i  in  2  available_o of buffer 0/1
- buf_grant_o  out  2  one-hot, one-cycle grant to buffer 0/1
- wsel_o  out  1  buffer index receiving W beats
- drain_o  out  1  external mux forces wready=1 and suppresses wvalid to both buffers
- fill_done_o  out  1  one-cycle pulse on an OKAY response
- fill_idx_o  out  1  buffer just filled; valid with fill_done_o

Behaviour:
- Reset values: awready 0, bvalid 0, bresp 00, grant 00, wsel 0, drain 0, fill_done 0, fill_idx 0. Internal state: wr_ptr=0, beat_cnt=0, state IDLE.
- Reset asserted mid-burst returns to IDLE the next edge. All outputs drop to reset values. The in-flight burst is abandoned and receives no B response.

States:
- IDLE
  - awready = buf_available_i[wr_ptr] (combinational).
  - On AW handshake, latch error flag = (awburst!=01) | (awlen!=BEATS_g-1) | (awsize!=3) | (awaddr[2:0]!=0).
  - Legal burst: buf_grant_o[wr_ptr]=1 for exactly the next cycle; wsel=wr_ptr; go WRITE.
  - Illegal burst: drain=1, no grant; go WRITE.
- WRITE
  - awready=0.
  - beat_cnt increments on wvalid & wready (8-bit, no wrap needed since awlen ≤ 255).
  - On the handshake with wlast=1, go RESP. Error flag is also set if beat_cnt+1 != latched awlen+1.
  - A beat beyond BEATS_g without wlast sets the error flag. From then on, drain=1 so the overflow cannot reach the full buffer.
- RESP
  - bvalid=1, bresp = error ? 10 : 00. Hold both stable until bready.
  - On the B handshake:
    - OKAY: pulse fill_done with fill_idx=wr_ptr, and toggle wr_ptr.
    - SLVERR: keep wr_ptr.
  - Clear beat_cnt and drain; go IDLE.
- Earliest next AW acceptance is the cycle after the B handshake (no AW/B overlap).
- Total latency, legal burst, all signals ready: AW handshake at cycle 0, grant at cycle 1, first beat ≥ cycle 2, bvalid the cycle after the wlast beat.
- If both buffers are unavailable, AW stalls indefinitely; awready stays 0.
- If a buffer's available_i falls while that buffer is granted, the W stream still stalls on that buffer's wready. No timeout is applied.

Optional Feature:
- Macro DBUF_WRITE_SCHED_PERF_EN.
- When defined, adds outputs perf_bursts_o[31:0] and perf_stall_o[31:0].
  - perf_bursts_o counts OKAY B handshakes.
  - perf_stall_o counts cycles with awvalid=1 and awready=0 while in IDLE.
  - Both are saturating and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Legal burst: awlen=15, awburst=01, awsize=3, both buffers available → grant=01 one cycle after the AW handshake, wsel=0, 16 beats, bresp=00, fill_done with idx 0, wr_ptr becomes 1.
- Two back-to-back legal bursts → grants 01 then 10. A third burst with buf_available_i=2'b10 holds awready=0 until bit0 rises.
- awburst=00 (FIXED), awlen=15 → no grant, drain=1 for 16 beats, bresp=10, no fill_done, wr_ptr unchanged.
- awlen=15 but wlast on beat 10 → bresp=10, no fill_done.
- bready held low 5 cycles → bvalid and bresp stable, awready=0 throughout. Release → fill_done pulses the same edge as the B handshake.
- rst_i asserted at beat 7 → next cycle all outputs at reset values. A new legal burst then targets buffer 0.

Source files
------------

// File: rtl/dbuf_write_sched.sv
// Ping-pong write scheduler for the two blocking buffers feeding the systolic
// array. Accepts AXI4 AW bursts, grants the target buffer, steers W beats,
// checks burst legality and generates the B response.
// Optional feature: define DBUF_WRITE_SCHED_PERF_EN to add saturating
// performance counters (perf_bursts_o, perf_stall_o).
module dbuf_write_sched #(
  parameter int unsigned AXI_DW_g = 64,
  parameter int unsigned AXI_AW_g = 32,
  parameter int unsigned BEATS_g  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_axi_awvalid_i,
  output logic                s_axi_awready_o,
  input  logic [AXI_AW_g-1:0] s_axi_awaddr_i,
  input  logic [7:0]          s_axi_awlen_i,
  input  logic [2:0]          s_axi_awsize_i,
  input  logic [1:0]          s_axi_awburst_i,
  input  logic                s_axi_wvalid_i,
  input  logic                s_axi_wready_i,
  input  logic                s_axi_wlast_i,
  output logic                s_axi_bvalid_o,
  input  logic                s_axi_bready_i,
  output logic [1:0]          s_axi_bresp_o,
  input  logic [1:0]          buf_available_i,
  output logic [1:0]          buf_grant_o,
  output logic                wsel_o,
  output logic                drain_o,
  output logic                fill_done_o,
`ifdef DBUF_WRITE_SCHED_PERF_EN
  output logic [31:0]         perf_bursts_o,
  output logic [31:0]         perf_stall_o,
`endif
  output logic                fill_idx_o
);

  localparam logic [7:0] LEN_LEGAL_c = 8'(BEATS_g - 1);
  localparam logic [8:0] BEATS_c     = 9'(BEATS_g);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] awlen_q, awlen_d;
  logic       err_q, err_d;
  logic       drain_q, drain_d;
  logic       wsel_q, wsel_d;
  logic [1:0] grant_q, grant_d;
  logic       fill_done_q, fill_done_d;
  logic       fill_idx_q, fill_idx_d;

  logic       awready;
  logic       bvalid;
  logic [1:0] bresp;
  logic       aw_illegal;
  logic       w_hs;
  logic       b_hs;
  logic [8:0] beat_next;

  // Only the low address bits carry meaning; the rest are intentionally unused.
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr_i[AXI_AW_g-1:3], AXI_DW_g[0]};

  assign aw_illegal = (s_axi_awburst_i != 2'b01) | (s_axi_awlen_i != LEN_LEGAL_c) |
                      (s_axi_awsize_i != 3'd3) | (s_axi_awaddr_i[2:0] != 3'b000);
  assign w_hs       = s_axi_wvalid_i & s_axi_wready_i;
  assign b_hs       = bvalid & s_axi_bready_i;
  assign beat_next  = {1'b0, beat_cnt_q} + 9'd1;

  // Next-state and handshake outputs for the IDLE/WRITE/RESP sequence.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    awlen_d     = awlen_q;
    err_d       = err_q;
    drain_d     = drain_q;
    wsel_d      = wsel_q;
    grant_d     = 2'b00;
    fill_done_d = 1'b0;
    fill_idx_d  = fill_idx_q;
    awready     = 1'b0;
    bvalid      = 1'b0;
    bresp       = 2'b00;
    unique case (state_q)
      IDLE: begin
        awready = buf_available_i[wr_ptr_q];
        if (s_axi_awvalid_i && awready) begin
          awlen_d    = s_axi_awlen_i;
          err_d      = aw_illegal;
          beat_cnt_d = 8'd0;
          state_d    = WRITE;
          if (aw_illegal) begin
            // Illegal bursts are swallowed by the drain path, no buffer sees them.
            drain_d = 1'b1;
          end else begin
            grant_d[wr_ptr_q] = 1'b1;
            wsel_d            = wr_ptr_q;
            drain_d           = 1'b0;
          end
        end
      end
      WRITE: begin
        if (w_hs) begin
          if (beat_cnt_q != 8'hFF) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
          if (s_axi_wlast_i) begin
            if (beat_next != ({1'b0, awlen_q} + 9'd1)) begin
              err_d = 1'b1;
            end
            state_d = RESP;
          end else if (beat_next >= BEATS_c) begin
            // Buffer is full and more beats follow: divert the rest away from it.
            err_d   = 1'b1;
            drain_d = 1'b1;
          end
        end
      end
      RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (s_axi_bready_i) begin
          if (!err_q) begin
            fill_done_d = 1'b1;
            fill_idx_d  = wr_ptr_q;
            wr_ptr_d    = ~wr_ptr_q;
          end
          beat_cnt_d = 8'd0;
          drain_d    = 1'b0;
          err_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 1'b0;
      beat_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      drain_q     <= 1'b0;
      wsel_q      <= 1'b0;
      grant_q     <= 2'b00;
      fill_done_q <= 1'b0;
      fill_idx_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      drain_q     <= drain_d;
      wsel_q      <= wsel_d;
      grant_q     <= grant_d;
      fill_done_q <= fill_done_d;
      fill_idx_q  <= fill_idx_d;
    end
  end

  // Latched burst length; only meaningful while a burst is in flight.
  always_ff @(posedge clk_i) begin
    awlen_q <= awlen_d;
  end

`ifdef DBUF_WRITE_SCHED_PERF_EN
  logic [31:0] perf_bursts_q;
  logic [31:0] perf_stall_q;

  // Saturating counters: OKAY completions and IDLE cycles with AW stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_bursts_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      if (b_hs && !err_q && (perf_bursts_q != 32'hFFFF_FFFF)) begin
        perf_bursts_q <= perf_bursts_q + 32'd1;
      end
      if ((state_q == IDLE) && s_axi_awvalid_i && !awready &&
          (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_bursts_o = perf_bursts_q;
  assign perf_stall_o  = perf_stall_q;
`else
  logic unused_b_hs;
  assign unused_b_hs = b_hs;
`endif

  assign s_axi_awready_o = awready & ~rst_i;
  assign s_axi_bvalid_o  = bvalid;
  assign s_axi_bresp_o   = bresp;
  assign buf_grant_o     = grant_q;
  assign wsel_o          = wsel_q;
  assign drain_o         = drain_q;
  assign fill_done_o     = fill_done_q;
  assign fill_idx_o      = fill_idx_q;

endmodule

// File: tb/tb_dbuf_write_sched.sv
// Self-checking bench for dbuf_write_sched: expected B responses are queued
// when a burst is issued and compared when the DUT raises bvalid.
module tb_dbuf_write_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [1:0]  avail;
  logic [1:0]  grant;
  logic        wsel;
  logic        drain;
  logic        fill_done;
  logic        fill_idx;
`ifdef DBUF_WRITE_SCHED_PERF_EN
  logic [31:0] perf_bursts;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  dbuf_write_sched #(.AXI_DW_g(64), .AXI_AW_g(32), .BEATS_g(16)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .s_axi_awvalid_i(awvalid),
    .s_axi_awready_o(awready),
    .s_axi_awaddr_i(awaddr),
    .s_axi_awlen_i(awlen),
    .s_axi_awsize_i(awsize),
    .s_axi_awburst_i(awburst),
    .s_axi_wvalid_i(wvalid),
    .s_axi_wready_i(wready),
    .s_axi_wlast_i(wlast),
    .s_axi_bvalid_o(bvalid),
    .s_axi_bready_i(bready),
    .s_axi_bresp_o(bresp),
    .buf_available_i(avail),
    .buf_grant_o(grant),
    .wsel_o(wsel),
    .drain_o(drain),
    .fill_done_o(fill_done),
`ifdef DBUF_WRITE_SCHED_PERF_EN
    .perf_bursts_o(perf_bursts),
    .perf_stall_o(perf_stall),
`endif
    .fill_idx_o(fill_idx)
  );

  typedef struct {
    logic [1:0] resp;
    logic       fill;
    logic       idx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_ptr  = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one AW request, check the grant/drain reaction and queue the B expectation.
  task automatic send_aw(input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                         input logic [31:0] addr, input logic [1:0] exp_resp);
    logic legal;
    int   waited;
    exp_t e;
    legal   = (burst == 2'b01) && (len == 8'd15) && (size == 3'd3) && (addr[2:0] == 3'b000);
    awvalid = 1'b1;
    awlen   = len;
    awburst = burst;
    awsize  = size;
    awaddr  = addr;
    #1;
    waited = 0;
    while (!awready && waited < 50) begin
      cyc();
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      $display("FAIL aw_timeout: awready never rose (got %0b want 1)", awready);
    end
    cyc();
    awvalid = 1'b0;
    n_checks++;
    if (grant !== (legal ? (2'b01 << exp_ptr) : 2'b00))
      $display("FAIL aw_grant: got %b want %b", grant, legal ? (2'b01 << exp_ptr) : 2'b00);
    else n_pass++;
    n_checks++;
    if (drain !== !legal) $display("FAIL aw_drain: got %b want %b", drain, !legal);
    else n_pass++;
    if (legal) begin
      n_checks++;
      if (wsel !== exp_ptr) $display("FAIL aw_wsel: got %b want %b", wsel, exp_ptr);
      else n_pass++;
    end
    e.resp = exp_resp;
    e.fill = (exp_resp == 2'b00);
    e.idx  = exp_ptr;
    sb.push_back(e);
    cyc();
    n_checks++;
    if (grant !== 2'b00) $display("FAIL grant_pulse: got %b want 00", grant);
    else n_pass++;
  endtask

  // Push n beats, wlast on beat last_at; optionally check drain on every beat.
  task automatic send_beats(input int n, input int last_at, input logic chk_drain);
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1;
      wready = 1'b1;
      wlast  = ((i + 1) == last_at);
      cyc();
      if (chk_drain) begin
        n_checks++;
        if (drain !== 1'b1) $display("FAIL beat_drain: beat %0d got %b want 1", i, drain);
        else n_pass++;
      end
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  // Wait for bvalid, compare against the scoreboard, optionally stall bready.
  task automatic recv_b(input int stall);
    int   waited;
    exp_t e;
    waited = 0;
    while (!bvalid && waited < 50) begin
      cyc();
      waited++;
    end
    n_checks++;
    if (waited != 0) $display("FAIL b_latency: bvalid after %0d extra cycles, want 0", waited);
    else n_pass++;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: response with no queued expectation (got %0d want 1)", sb.size());
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (bresp !== e.resp) $display("FAIL bresp: got %b want %b", bresp, e.resp);
    else n_pass++;
    for (int i = 0; i < stall; i++) begin
      bready = 1'b0;
      cyc();
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== e.resp || awready !== 1'b0 || fill_done !== 1'b0)
        $display("FAIL b_hold: bvalid=%b bresp=%b awready=%b fill_done=%b want 1 %b 0 0",
                 bvalid, bresp, awready, fill_done, e.resp);
      else n_pass++;
    end
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    n_checks++;
    if (fill_done !== e.fill) $display("FAIL fill_done: got %b want %b", fill_done, e.fill);
    else n_pass++;
    if (e.fill) begin
      n_checks++;
      if (fill_idx !== e.idx) $display("FAIL fill_idx: got %b want %b", fill_idx, e.idx);
      else n_pass++;
      exp_ptr = ~exp_ptr;
    end
    n_checks++;
    if (bvalid !== 1'b0) $display("FAIL b_drop: bvalid got %b want 0", bvalid);
    else n_pass++;
    cyc();
    n_checks++;
    if (fill_done !== 1'b0) $display("FAIL fill_pulse: got %b want 0", fill_done);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if ({awready, bvalid, bresp, grant, wsel, drain, fill_done, fill_idx} !== 10'b0)
      $display("FAIL %s: aw=%b bv=%b br=%b gr=%b ws=%b dr=%b fd=%b fi=%b want all 0",
               tag, awready, bvalid, bresp, grant, wsel, drain, fill_done, fill_idx);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    #1;
    n_checks++;
    if (awready !== 1'b1) $display("FAIL idle_awready: got %b want 1", awready);
    else n_pass++;
  endtask

  task automatic test_legal();
    send_aw(8'd15, 2'b01, 3'd3, 32'h1000, 2'b00);
    send_beats(16, 16, 1'b0);
    recv_b(0);
  endtask

  task automatic test_illegal_burst();
    send_aw(8'd15, 2'b00, 3'd3, 32'h2000, 2'b10);
    send_beats(16, 16, 1'b1);
    recv_b(0);
  endtask

  task automatic test_early_wlast();
    send_aw(8'd15, 2'b01, 3'd3, 32'h3000, 2'b10);
    send_beats(10, 10, 1'b0);
    recv_b(0);
  endtask

  task automatic test_bready_stall();
    send_aw(8'd15, 2'b01, 3'd3, 32'h4000, 2'b00);
    send_beats(16, 16, 1'b0);
    recv_b(5);
  endtask

  task automatic test_back_to_back();
    send_aw(8'd15, 2'b01, 3'd3, 32'h5000, 2'b00);
    send_beats(16, 16, 1'b0);
    recv_b(0);
    send_aw(8'd15, 2'b01, 3'd3, 32'h5080, 2'b00);
    send_beats(16, 16, 1'b0);
    recv_b(0);
    avail   = 2'b10;
    awvalid = 1'b1;
    awlen   = 8'd15;
    awburst = 2'b01;
    awsize  = 3'd3;
    awaddr  = 32'h5100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (awready !== 1'b0) $display("FAIL aw_stall: cycle %0d got %b want 0", i, awready);
      else n_pass++;
    end
    avail = 2'b11;
    send_aw(8'd15, 2'b01, 3'd3, 32'h5100, 2'b00);
    send_beats(16, 16, 1'b0);
    recv_b(0);
  endtask

  task automatic test_reset_mid_burst();
    send_aw(8'd15, 2'b01, 3'd3, 32'h6000, 2'b00);
    send_beats(7, 0, 1'b0);
    rst = 1'b1;
    cyc();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    sb.delete();
    exp_ptr = 1'b0;
    cyc();
    n_checks++;
    if (bvalid !== 1'b0) $display("FAIL abandoned_b: bvalid got %b want 0", bvalid);
    else n_pass++;
    send_aw(8'd15, 2'b01, 3'd3, 32'h7000, 2'b00);
    send_beats(16, 16, 1'b0);
    recv_b(0);
  endtask

  initial begin
    rst     = 1'b1;
    awvalid = 1'b0;
    awaddr  = 32'h0;
    awlen   = 8'd0;
    awsize  = 3'd0;
    awburst = 2'b00;
    wvalid  = 1'b0;
    wready  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    avail   = 2'b11;
    test_reset();
    test_legal();
    test_illegal_burst();
    test_early_wlast();
    test_bready_stall();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
